// File: rtl/bg_multi_layer.sv
// Multi-layer scrolling background address generator: per-layer shadow/active
// register banks committed on frame start, and a 2-stage pixel-to-tile pipeline.
module bg_multi_layer #(
    parameter int LAYERS    = 2,
    parameter int SX_W      = 10,
    parameter int MAP_LOG2  = 6,
    parameter int TILE_LOG2 = 3,
    parameter int ADDR_W    = 16,
    localparam int LA_W     = (LAYERS > 1) ? $clog2(LAYERS) : 1,
    localparam int SCR_W    = MAP_LOG2 + TILE_LOG2
) (
    input  logic                        iCLOCK,
    input  logic                        iRESET,
    input  logic [SX_W-1:0]             iSX,
    input  logic [SX_W-1:0]             iSY,
    input  logic                        iPIX_VALID,
    input  logic                        iFRAME_START,
    input  logic [LA_W+1:0]             iREG_ADDR,
    input  logic [31:0]                 iREG_DATA,
    input  logic                        iREG_WRITE,
    output logic [LAYERS*ADDR_W-1:0]    oMAP_ADDR,
    output logic [LAYERS*TILE_LOG2-1:0] oFINE_X,
    output logic [LAYERS*TILE_LOG2-1:0] oFINE_Y,
    output logic [LAYERS-1:0]           oLAYER_EN,
    output logic                        oVALID,
    output logic                        oPENDING
);

    localparam int SUM_W = ((SX_W > SCR_W) ? SX_W : SCR_W) + 1;
    localparam int IDX_W = 2 * MAP_LOG2;
    localparam int EXT_W = ADDR_W + IDX_W;
    localparam logic [LA_W:0] LAYERS_V = LAYERS[LA_W:0];

    // Pixel path is valid-only: iPIX_VALID qualifies iSX/iSY, oVALID qualifies
    // the outputs two cycles later; there is no ready and no back-pressure.

    logic [LA_W-1:0] wr_layer;
    logic [1:0]      wr_reg;
    logic            wr_ok;
    logic            unused_data;

    assign wr_layer    = iREG_ADDR[LA_W+1:2];
    assign wr_reg      = iREG_ADDR[1:0];
    assign wr_ok       = iREG_WRITE && ({1'b0, wr_layer} < LAYERS_V);
    assign unused_data = ^iREG_DATA;

    logic [SCR_W-1:0]  sh_sx   [LAYERS];
    logic [SCR_W-1:0]  sh_sy   [LAYERS];
    logic [ADDR_W-1:0] sh_base [LAYERS];
    logic              sh_en   [LAYERS];
    logic              sh_wrap [LAYERS];
    logic [SCR_W-1:0]  act_sx  [LAYERS];
    logic [SCR_W-1:0]  act_sy  [LAYERS];
    logic [ADDR_W-1:0] act_base[LAYERS];
    logic              act_en  [LAYERS];
    logic              act_wrap[LAYERS];

    // Commit reads the shadow before this cycle's write lands, so a write
    // coincident with frame start stays pending for the next commit.
    always_ff @(posedge iCLOCK or posedge iRESET) begin
        if (iRESET) begin
            for (int l = 0; l < LAYERS; l++) begin
                sh_sx[l]    <= '0;
                sh_sy[l]    <= '0;
                sh_base[l]  <= '0;
                sh_en[l]    <= 1'b0;
                sh_wrap[l]  <= 1'b0;
                act_sx[l]   <= '0;
                act_sy[l]   <= '0;
                act_base[l] <= '0;
                act_en[l]   <= 1'b0;
                act_wrap[l] <= 1'b0;
            end
            oPENDING <= 1'b0;
        end else begin
            for (int l = 0; l < LAYERS; l++) begin
                if (iFRAME_START) begin
                    act_sx[l]   <= sh_sx[l];
                    act_sy[l]   <= sh_sy[l];
                    act_base[l] <= sh_base[l];
                    act_en[l]   <= sh_en[l];
                    act_wrap[l] <= sh_wrap[l];
                end
                if (wr_ok && (wr_layer == l[LA_W-1:0])) begin
                    case (wr_reg)
                        2'd0: sh_sx[l]   <= iREG_DATA[SCR_W-1:0];
                        2'd1: sh_sy[l]   <= iREG_DATA[SCR_W-1:0];
                        2'd2: sh_base[l] <= iREG_DATA[ADDR_W-1:0];
                        default: begin
                            sh_en[l]   <= iREG_DATA[0];
                            sh_wrap[l] <= iREG_DATA[1];
                        end
                    endcase
                end
            end
            if (wr_ok) begin
                oPENDING <= 1'b1;
            end else if (iFRAME_START) begin
                oPENDING <= 1'b0;
            end
        end
    end

    logic              v1;
    logic [SUM_W-1:0]  s1_x   [LAYERS];
    logic [SUM_W-1:0]  s1_y   [LAYERS];
    logic [ADDR_W-1:0] s1_base[LAYERS];
    logic              s1_en  [LAYERS];
    logic              s1_wrap[LAYERS];

    always_ff @(posedge iCLOCK or posedge iRESET) begin
        if (iRESET) begin
            v1 <= 1'b0;
            for (int l = 0; l < LAYERS; l++) begin
                s1_x[l]    <= '0;
                s1_y[l]    <= '0;
                s1_base[l] <= '0;
                s1_en[l]   <= 1'b0;
                s1_wrap[l] <= 1'b0;
            end
        end else begin
            v1 <= iPIX_VALID;
            if (iPIX_VALID) begin
                for (int l = 0; l < LAYERS; l++) begin
                    s1_x[l]    <= SUM_W'(iSX) + SUM_W'(act_sx[l]);
                    s1_y[l]    <= SUM_W'(iSY) + SUM_W'(act_sy[l]);
                    s1_base[l] <= act_base[l];
                    s1_en[l]   <= act_en[l];
                    s1_wrap[l] <= act_wrap[l];
                end
            end
        end
    end

    logic [SCR_W-1:0]  wx     [LAYERS];
    logic [SCR_W-1:0]  wy     [LAYERS];
    logic              oor    [LAYERS];
    logic [EXT_W-1:0]  addr_x [LAYERS];
    logic              en_c   [LAYERS];

    // The map index {tile_y, tile_x} equals (tile_y << MAP_LOG2) + tile_x.
    always_comb begin
        for (int l = 0; l < LAYERS; l++) begin
            wx[l]     = s1_x[l][SCR_W-1:0];
            wy[l]     = s1_y[l][SCR_W-1:0];
            oor[l]    = (|s1_x[l][SUM_W-1:SCR_W]) || (|s1_y[l][SUM_W-1:SCR_W]);
            en_c[l]   = s1_en[l] && (s1_wrap[l] || !oor[l]);
            addr_x[l] = EXT_W'(s1_base[l])
                      + EXT_W'({wy[l][SCR_W-1:TILE_LOG2], wx[l][SCR_W-1:TILE_LOG2]});
        end
    end

    always_ff @(posedge iCLOCK or posedge iRESET) begin
        if (iRESET) begin
            oVALID    <= 1'b0;
            oMAP_ADDR <= '0;
            oFINE_X   <= '0;
            oFINE_Y   <= '0;
            oLAYER_EN <= '0;
        end else begin
            oVALID <= v1;
            if (v1) begin
                for (int l = 0; l < LAYERS; l++) begin
                    oMAP_ADDR[l*ADDR_W +: ADDR_W]      <= addr_x[l][ADDR_W-1:0];
                    oFINE_X[l*TILE_LOG2 +: TILE_LOG2] <= wx[l][TILE_LOG2-1:0];
                    oFINE_Y[l*TILE_LOG2 +: TILE_LOG2] <= wy[l][TILE_LOG2-1:0];
                    oLAYER_EN[l]                       <= en_c[l];
                end
            end
        end
    end

endmodule

// File: tb/tb_bg_multi_layer.sv
// Bench for bg_multi_layer: directed register/commit scenarios plus random
// traffic, checked every cycle against a tile-arithmetic reference model.
module tb_bg_multi_layer;

  localparam int LAYERS    = 3;
  localparam int SX_W      = 10;
  localparam int MAP_LOG2  = 6;
  localparam int TILE_LOG2 = 3;
  localparam int ADDR_W    = 16;
  localparam int SCR       = 1 << (MAP_LOG2 + TILE_LOG2);
  localparam int TILE      = 1 << TILE_LOG2;
  localparam int MAPN      = 1 << MAP_LOG2;
  localparam int RW        = 1 + LAYERS * (1 + 2 * TILE_LOG2 + ADDR_W);

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                        rst;
  logic [SX_W-1:0]             sx_i, sy_i;
  logic                        pv, fs, wr;
  logic [3:0]                  wa;
  logic [31:0]                 wd;
  logic [LAYERS*ADDR_W-1:0]    map_addr;
  logic [LAYERS*TILE_LOG2-1:0] fine_x, fine_y;
  logic [LAYERS-1:0]           layer_en;
  logic                        valid, pending;

  bg_multi_layer #(
    .LAYERS(LAYERS), .SX_W(SX_W), .MAP_LOG2(MAP_LOG2),
    .TILE_LOG2(TILE_LOG2), .ADDR_W(ADDR_W)
  ) dut (
    .iCLOCK(clk), .iRESET(rst), .iSX(sx_i), .iSY(sy_i),
    .iPIX_VALID(pv), .iFRAME_START(fs), .iREG_ADDR(wa),
    .iREG_DATA(wd), .iREG_WRITE(wr), .oMAP_ADDR(map_addr),
    .oFINE_X(fine_x), .oFINE_Y(fine_y), .oLAYER_EN(layer_en),
    .oVALID(valid), .oPENDING(pending)
  );

  // reference model state
  int sh_sx[LAYERS], sh_sy[LAYERS], sh_base[LAYERS];
  bit sh_en[LAYERS], sh_wrap[LAYERS];
  int act_sx[LAYERS], act_sy[LAYERS], act_base[LAYERS];
  bit act_en[LAYERS], act_wrap[LAYERS];
  bit m_pend;

  // scoreboard: one record per cycle, {valid, en, fine_y, fine_x, addr}
  logic [RW-1:0]              exp_q[$];
  logic                       exp_v;
  logic [LAYERS*ADDR_W-1:0]   exp_addr;
  logic [LAYERS*TILE_LOG2-1:0] exp_fx, exp_fy;
  logic [LAYERS-1:0]          exp_en;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
  endtask

  task automatic model_clear();
    for (int l = 0; l < LAYERS; l++) begin
      sh_sx[l] = 0; sh_sy[l] = 0; sh_base[l] = 0; sh_en[l] = 0; sh_wrap[l] = 0;
      act_sx[l] = 0; act_sy[l] = 0; act_base[l] = 0; act_en[l] = 0; act_wrap[l] = 0;
    end
    m_pend = 0;
    exp_q.delete();
    exp_v = 0; exp_addr = '0; exp_fx = '0; exp_fy = '0; exp_en = '0;
  endtask

  // Called just after each rising edge with the inputs that edge sampled.
  task automatic model_edge();
    logic [RW-1:0] rec, out;
    logic [LAYERS*ADDR_W-1:0] a;
    logic [LAYERS*TILE_LOG2-1:0] fx, fy;
    logic [LAYERS-1:0] en;
    int x, y, xw, yw, layer, rsel;
    bit oob;
    if (rst) begin
      model_clear();
      return;
    end
    a = '0; fx = '0; fy = '0; en = '0;
    if (pv) begin
      for (int l = 0; l < LAYERS; l++) begin
        x   = int'(sx_i) + act_sx[l];
        y   = int'(sy_i) + act_sy[l];
        oob = (x >= SCR) || (y >= SCR);
        xw  = x % SCR;
        yw  = y % SCR;
        en[l] = act_en[l] && (act_wrap[l] || !oob);
        fx[l*TILE_LOG2 +: TILE_LOG2] = TILE_LOG2'(xw % TILE);
        fy[l*TILE_LOG2 +: TILE_LOG2] = TILE_LOG2'(yw % TILE);
        a[l*ADDR_W +: ADDR_W] = ADDR_W'((act_base[l] + (yw / TILE) * MAPN + (xw / TILE)) % 65536);
      end
    end
    rec = {pv, en, fy, fx, a};
    exp_q.push_back(rec);
    if (exp_q.size() > 1) begin
      out = exp_q.pop_front();
      exp_v = out[RW-1];
      if (exp_v) {exp_en, exp_fy, exp_fx, exp_addr} = out[RW-2:0];
    end else begin
      exp_v = 0;
    end
    if (fs) begin
      act_sx = sh_sx; act_sy = sh_sy; act_base = sh_base;
      act_en = sh_en; act_wrap = sh_wrap;
    end
    layer = int'(wa) / 4;
    rsel  = int'(wa) % 4;
    if (wr && layer < LAYERS) begin
      m_pend = 1;
      case (rsel)
        0: sh_sx[layer] = int'(wd) & (SCR - 1);
        1: sh_sy[layer] = int'(wd) & (SCR - 1);
        2: sh_base[layer] = int'(wd) & 16'hFFFF;
        default: begin
          sh_en[layer]   = wd[0];
          sh_wrap[layer] = wd[1];
        end
      endcase
    end else if (fs) begin
      m_pend = 0;
    end
  endtask

  task automatic check_all();
    check("valid", 64'(valid), 64'(exp_v));
    check("pending", 64'(pending), 64'(m_pend));
    check("map_addr", 64'(map_addr), 64'(exp_addr));
    check("fine_x", 64'(fine_x), 64'(exp_fx));
    check("fine_y", 64'(fine_y), 64'(exp_fy));
    check("layer_en", 64'(layer_en), 64'(exp_en));
  endtask

  // driver: one clock cycle of stimulus, model update, then output check
  task automatic cyc(input bit r, input bit p, input int x, input int y,
                     input bit f, input bit w, input int a, input logic [31:0] d);
    rst = r; pv = p; sx_i = x[SX_W-1:0]; sy_i = y[SX_W-1:0];
    fs = f; wr = w; wa = a[3:0]; wd = d;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_all();
  endtask

  task automatic idle();                               cyc(0, 0, 0, 0, 0, 0, 0, 0); endtask
  task automatic pix(input int x, input int y);        cyc(0, 1, x, y, 0, 0, 0, 0); endtask
  task automatic wreg(input int a, input logic [31:0] d); cyc(0, 0, 0, 0, 0, 1, a, d); endtask
  task automatic commit();                             cyc(0, 0, 0, 0, 1, 0, 0, 0); endtask

  initial begin
    int vcount;
    model_clear();
    rst = 1; pv = 0; sx_i = '0; sy_i = '0; fs = 0; wr = 0; wa = '0; wd = '0;
    @(negedge clk);
    cyc(1, 0, 0, 0, 0, 0, 0, 0);
    cyc(1, 1, 7, 7, 0, 0, 0, 0);
    check("rst_valid", 64'(valid), 64'(0));
    check("rst_addr", 64'(map_addr), 64'(0));

    // mid-stream reset with pixels in flight
    wreg(2, 32'h0000_0123); wreg(3, 1); commit();
    pix(1, 2); pix(9, 3); pix(17, 4);
    cyc(1, 1, 5, 5, 0, 0, 0, 0);
    check("r34_addr0", 64'(map_addr), 64'(0));
    check("r34_valid0", 64'(valid), 64'(0));
    pix(3, 3);
    check("r34_wait", 64'(valid), 64'(0));
    idle();
    check("r34_first", 64'(valid), 64'(1));

    // shadow write does not affect pixels until commit
    wreg(0, 5); wreg(3, 1);
    pix(3, 0); idle();
    check("r35_en_pre", 64'(layer_en[0]), 64'(0));
    check("r35_pend_pre", 64'(pending), 64'(1));
    commit();
    pix(3, 0); idle();
    check("r35_addr", 64'(map_addr[15:0]), 64'(16'h0001));
    check("r35_fx", 64'(fine_x[2:0]), 64'(0));
    check("r35_en", 64'(layer_en[0]), 64'(1));
    check("r35_pend", 64'(pending), 64'(0));

    // wrap across the right edge of the map
    wreg(6, 32'h0000_1000); wreg(4, 510); wreg(7, 3); commit();
    pix(4, 9); idle();
    check("r36_addr", 64'(map_addr[31:16]), 64'(16'h1040));
    check("r36_fx", 64'(fine_x[5:3]), 64'(2));
    check("r36_fy", 64'(fine_y[5:3]), 64'(1));
    check("r36_en", 64'(layer_en[1]), 64'(1));
    wreg(7, 1); commit();
    pix(4, 9); idle();
    check("r36_nowrap", 64'(layer_en[1]), 64'(0));

    // write coincident with commit stays shadow-only
    cyc(0, 0, 0, 0, 1, 1, 9, 7);
    check("r37_pend", 64'(pending), 64'(1));
    pix(0, 1); idle();
    check("r37_fy_old", 64'(fine_y[8:6]), 64'(1));
    commit();
    pix(0, 1); idle();
    check("r37_addr", 64'(map_addr[47:32]), 64'(16'h0040));
    check("r37_fy", 64'(fine_y[8:6]), 64'(0));

    // out-of-range layer index is ignored
    wreg(12, 32'hFFFF_FFFF);
    check("r38_pend", 64'(pending), 64'(0));
    commit();
    pix(100, 200); idle();

    // back-to-back stream with a commit in the middle
    wreg(0, 64); wreg(5, 300); wreg(11, 2);
    vcount = 0;
    for (int i = 0; i < 10; i++) begin
      cyc(0, i < 8, 8 * i + 1, 3 * i, i == 3, 0, 0, 0);
      vcount += int'(valid);
    end
    check("r39_count", 64'(vcount), 64'(8));

    // random traffic
    for (int i = 0; i < 1500; i++) begin
      cyc($urandom_range(0, 299) == 0,
          $urandom_range(0, 3) != 0,
          $urandom_range(0, (1 << SX_W) - 1),
          $urandom_range(0, (1 << SX_W) - 1),
          $urandom_range(0, 11) == 0,
          $urandom_range(0, 2) == 0,
          $urandom_range(0, 15),
          $urandom);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
